auto_corner_detector: RTL

//  Automatic corner-detection stage. main_fsm launches it with auto_detection_start
//  and waits for its auto_detection_done. The block scans one thresholded marker

---
 rtl/auto_corner_detector_pkg.sv | 20 ++
 rtl/auto_corner_detector_corner_tracker.sv | 48 ++++
 rtl/auto_corner_detector.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/auto_corner_detector_pkg.sv
// Shared frame defaults, FSM encoding and tracker modes for the auto corner detector.
// main_fsm imports the same state encoding so both sides agree on it.
package auto_corner_detector_pkg;

  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } detect_state_e;

  typedef enum logic {
    MODE_MIN = 1'b0,
    MODE_MAX = 1'b1
  } track_mode_e;

endpackage

// File: rtl/auto_corner_detector_corner_tracker.sv
// Tracks the coordinate with the extreme key (min or max) among valid samples.
// Strict comparison keeps the first sample on a tie.
module corner_tracker
  import auto_corner_detector_pkg::*;
#(
  parameter int          KW   = 11,
  parameter int          XW   = 10,
  parameter int          YW   = 9,
  parameter track_mode_e MODE = MODE_MIN
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          valid,
  input  logic [KW-1:0] key,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [XW-1:0] best_x,
  output logic [YW-1:0] best_y,
  output logic          seen
);

  logic [KW-1:0] best_key;
  logic          better;

  assign better = (MODE == MODE_MAX) ? (key > best_key) : (key < best_key);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_key <= '0;
      best_x   <= '0;
      best_y   <= '0;
      seen     <= 1'b0;
    end else if (clear) begin
      best_key <= '0;
      best_x   <= '0;
      best_y   <= '0;
      seen     <= 1'b0;
    end else if (valid && (!seen || better)) begin
      best_key <= key;
      best_x   <= x;
      best_y   <= y;
      seen     <= 1'b1;
    end
  end

endmodule

// File: rtl/auto_corner_detector.sv
// Raster-scans one thresholded frame from BRAM and reports the four extreme corners
// (TL/TR/BL/BR) of the marked quadrilateral, publishing them together with done.
module auto_corner_detector
  import auto_corner_detector_pkg::*;
#(
  parameter int WIDTH  = FRAME_WIDTH,
  parameter int HEIGHT = FRAME_HEIGHT,
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int AW     = 19,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] pix_addr,
  input  logic          pix_data,
  output logic          found,
  output logic [XW-1:0] tl_x,
  output logic [YW-1:0] tl_y,
  output logic [XW-1:0] tr_x,
  output logic [YW-1:0] tr_y,
  output logic [XW-1:0] bl_x,
  output logic [YW-1:0] bl_y,
  output logic [XW-1:0] br_x,
  output logic [YW-1:0] br_y
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int KW = XW + 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  detect_state_e state, state_next;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [DW-1:0] drain_cnt;
  logic          last_addr, drain_last, launch;

  assign last_addr  = (pix_addr == AW'(N - 1));
  assign drain_last = (drain_cnt == DW'(RD_LAT - 1));
  assign launch     = (state == ST_IDLE) && start;
  assign done       = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start)      state_next = ST_SCAN;
      ST_SCAN:  if (last_addr)  state_next = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_next = ST_DONE;
      ST_DONE:                  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // Address advances by increment; x/y follow it so no multiplier is needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_addr  <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (launch) begin
        pix_addr <= '0;
        x_cnt    <= '0;
        y_cnt    <= '0;
      end else if (state == ST_SCAN && !last_addr) begin
        pix_addr <= pix_addr + 1'b1;
        if (x_cnt == XW'(WIDTH - 1)) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  // Coordinates travel alongside the read so pix_data meets its own pixel.
  logic          sr_v [RD_LAT];
  logic [XW-1:0] sr_x [RD_LAT];
  logic [YW-1:0] sr_y [RD_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) sr_v[i] <= 1'b0;
    end else begin
      sr_v[0] <= (state == ST_SCAN);
      for (int i = 1; i < RD_LAT; i++) sr_v[i] <= sr_v[i-1];
    end
  end

  // NOTE: coordinate pipeline is qualified by sr_v, so it carries no reset.
  always_ff @(posedge clk) begin
    sr_x[0] <= x_cnt;
    sr_y[0] <= y_cnt;
    for (int i = 1; i < RD_LAT; i++) begin
      sr_x[i] <= sr_x[i-1];
      sr_y[i] <= sr_y[i-1];
    end
  end

  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [KW-1:0] key_sum, key_anti;
  logic          px_valid;

  assign px_x     = sr_x[RD_LAT-1];
  assign px_y     = sr_y[RD_LAT-1];
  assign px_valid = sr_v[RD_LAT-1] && pix_data;
  assign key_sum  = KW'(px_x) + KW'(px_y);
  assign key_anti = KW'(px_x) + KW'(HEIGHT - 1) - KW'(px_y);

  logic [XW-1:0] w_tl_x, w_tr_x, w_bl_x, w_br_x;
  logic [YW-1:0] w_tl_y, w_tr_y, w_bl_y, w_br_y;
  logic          s_tl, s_tr, s_bl, s_br;

  corner_tracker #(.KW(KW), .XW(XW), .YW(YW), .MODE(MODE_MIN)) u_tl (
    .clk(clk), .reset_n(reset_n), .clear(launch), .valid(px_valid), .key(key_sum),
    .x(px_x), .y(px_y), .best_x(w_tl_x), .best_y(w_tl_y), .seen(s_tl));
  corner_tracker #(.KW(KW), .XW(XW), .YW(YW), .MODE(MODE_MAX)) u_tr (
    .clk(clk), .reset_n(reset_n), .clear(launch), .valid(px_valid), .key(key_anti),
    .x(px_x), .y(px_y), .best_x(w_tr_x), .best_y(w_tr_y), .seen(s_tr));
  corner_tracker #(.KW(KW), .XW(XW), .YW(YW), .MODE(MODE_MIN)) u_bl (
    .clk(clk), .reset_n(reset_n), .clear(launch), .valid(px_valid), .key(key_anti),
    .x(px_x), .y(px_y), .best_x(w_bl_x), .best_y(w_bl_y), .seen(s_bl));
  corner_tracker #(.KW(KW), .XW(XW), .YW(YW), .MODE(MODE_MAX)) u_br (
    .clk(clk), .reset_n(reset_n), .clear(launch), .valid(px_valid), .key(key_sum),
    .x(px_x), .y(px_y), .best_x(w_br_x), .best_y(w_br_y), .seen(s_br));

  // Published result changes only on DONE, so partial scans are never visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found <= 1'b0;
      tl_x <= '0; tl_y <= '0; tr_x <= '0; tr_y <= '0;
      bl_x <= '0; bl_y <= '0; br_x <= '0; br_y <= '0;
    end else if (state == ST_DONE) begin
      found <= s_tl | s_tr | s_bl | s_br;
      tl_x <= w_tl_x; tl_y <= w_tl_y; tr_x <= w_tr_x; tr_y <= w_tr_y;
      bl_x <= w_bl_x; bl_y <= w_bl_y; br_x <= w_br_x; br_y <= w_br_y;
    end
  end

endmodule
